// File: rtl/gcd_param_engine_pkg.sv
// Shared definitions for the GCD engine: FSM state encoding (2 bits), used by RTL and bench.
package gcd_param_engine_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/gcd_sub_cmp.sv
// Combinational compare/subtract slice: equality, ordering and |ra-rb|.
module gcd_sub_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] ra,
    input  logic [WIDTH-1:0] rb,
    output logic             eq,
    output logic             a_gt_b,
    output logic [WIDTH-1:0] diff
);

    assign eq     = (ra == rb);
    assign a_gt_b = (ra > rb);
    // Larger operand is always the minuend, so this never wraps.
    assign diff   = a_gt_b ? (ra - rb) : (rb - ra);

endmodule

// File: rtl/gcd_param_engine.sv
// Multi-cycle GCD by repeated subtraction behind a start/done handshake.
// Build option GCD_ZERO_PASS_EN: a single zero operand passes the other through instead of erroring.
module gcd_param_engine
    import gcd_param_engine_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             done,
    output logic             error,
    output logic             busy,
    output logic [CNT_W-1:0] cycles
);

    state_t           state;
    logic [WIDTH-1:0] ra, rb, diff;
    logic             eq, a_gt_b;
    logic             a_zero, b_zero, zero_err, zero_pass;

    gcd_sub_cmp #(.WIDTH(WIDTH)) u_cmp (
        .ra     (ra),
        .rb     (rb),
        .eq     (eq),
        .a_gt_b (a_gt_b),
        .diff   (diff)
    );

    assign a_zero = (a == '0);
    assign b_zero = (b == '0);

`ifdef GCD_ZERO_PASS_EN
    assign zero_err  = a_zero & b_zero;
    assign zero_pass = a_zero ^ b_zero;
`else
    assign zero_err  = a_zero | b_zero;
    assign zero_pass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ra     <= '0;
            rb     <= '0;
            y      <= '0;
            done   <= 1'b0;
            error  <= 1'b0;
            busy   <= 1'b0;
            cycles <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ra     <= a;
                        rb     <= b;
                        cycles <= '0;
                        busy   <= 1'b1;
                        if (zero_err) begin
                            y     <= '0;
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else if (zero_pass) begin
                            y     <= a | b;
                            error <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (cycles != {CNT_W{1'b1}})
                        cycles <= cycles + 1'b1;
                    // The terminating equal-compare cycle is counted too.
                    if (eq) begin
                        y     <= ra;
                        error <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else if (a_gt_b) begin
                        ra <= diff;
                    end else begin
                        rb <= diff;
                    end
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
